datamem_ctrl: RTL and testbench

Two-port arbiter and access sequencer in front of the `datamem` X/Y-addressed data memory. It accepts load/store requests from two requesters over valid/ready handshakes, splits each flat address into the X (row) and Y (column) halves, and drives the single memory port one access at a time. It returns read data or a write acknowledge to the owning requester. It sits between the load/store unit (requester 0) and the debug/DMA port (requester 1) on one side and `datamem` on the other.

---
 rtl/datamem_ctrl_pkg.sv | 29 ++
 rtl/datamem_arb_pick.sv | 36 +++
 rtl/datamem_ctrl.sv | 126 ++++++++++++
 tb/tb_datamem_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datamem_ctrl_pkg.sv
// Shared types and constants for the datamem_ctrl arbiter/sequencer.
// The build-time option DATAMEM_CTRL_RR_EN is consumed by datamem_arb_pick.
package datamem_ctrl_pkg;

    localparam int NUM_REQ        = 2;
    localparam int DMC_ADDR_BITS  = 16;
    localparam int DMC_DATA_WIDTH = 64;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    // One latched request: direction, flat word address and write data.
    typedef struct packed {
        logic                      we;
        logic [DMC_ADDR_BITS-1:0]  addr;
        logic [DMC_DATA_WIDTH-1:0] wdata;
    } req_t;

    // Requester index to one-hot response/grant vector.
    function automatic logic [NUM_REQ-1:0] owner_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/datamem_arb_pick.sv
// Two-way combinational grant picker for datamem_ctrl.
// `DATAMEM_CTRL_RR_EN selects round-robin on contention; otherwise
// requester 0 has fixed priority and last_grant_i is ignored.
module datamem_arb_pick
    import datamem_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic               last_grant_i,
    output logic [NUM_REQ-1:0] grant_o
);

`ifndef DATAMEM_CTRL_RR_EN
    // Fixed priority still receives last_grant so the port list is identical.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

    // Pick exactly one requester from the valid vector.
    always_comb begin
        grant_o = '0;
        case (req_valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11: begin
`ifdef DATAMEM_CTRL_RR_EN
                // Contention: hand the port to whoever did not win last time.
                grant_o = last_grant_i ? 2'b01 : 2'b10;
`else
                grant_o = 2'b01;
`endif
            end
            default: grant_o = '0;
        endcase
    end

endmodule

// File: rtl/datamem_ctrl.sv
// Arbiter and access sequencer in front of the X/Y addressed datamem.
// Accepts one request at a time from two requesters, runs it through
// IDLE -> ACCESS -> WAIT -> RESP and returns data/ack to the owner.
// Arbitration policy is chosen by `DATAMEM_CTRL_RR_EN (see datamem_arb_pick).
//
// Handshakes: a request transfers in a cycle where req_valid[i] and
// req_ready[i] are both high (req_ready only ever rises in IDLE, for the
// granted requester); a response transfers in a cycle where resp_valid[i]
// and resp_ready[i] are both high, and resp_valid/resp_rdata hold until then.
//
// ADDR_BITS/DATA_WIDTH must match the package record widths.
module datamem_ctrl
    import datamem_ctrl_pkg::*;
#(
    parameter int ADDR_BITS  = DMC_ADDR_BITS,
    parameter int DATA_WIDTH = DMC_DATA_WIDTH
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [2*ADDR_BITS-1:0]    req_addr,
    input  logic [2*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic                      WriteEnable,
    output logic [ADDR_BITS/2-1:0]    X_addr,
    output logic [ADDR_BITS/2-1:0]    Y_addr,
    output logic [DATA_WIDTH-1:0]     Data_in,
    input  logic [DATA_WIDTH-1:0]     Data_out,
    output state_e                    dbg_state
);

    localparam int HALF = ADDR_BITS / 2;

    state_e                 state_q;
    req_t                   req_q;
    logic                   owner_q;
    logic                   last_grant_q;
    logic                   we_out_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic [NUM_REQ-1:0]     resp_valid_q;

    logic [NUM_REQ-1:0]     grant;
    req_t                   sel_req;

    datamem_arb_pick u_pick (
        .req_valid_i  (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    // Record of the granted requester, ready to be latched on acceptance.
    always_comb begin
        sel_req = '0;
        if (grant[1]) begin
            sel_req.we    = req_we[1];
            sel_req.addr  = req_addr[ADDR_BITS +: ADDR_BITS];
            sel_req.wdata = req_wdata[DATA_WIDTH +: DATA_WIDTH];
        end else begin
            sel_req.we    = req_we[0];
            sel_req.addr  = req_addr[0 +: ADDR_BITS];
            sel_req.wdata = req_wdata[0 +: DATA_WIDTH];
        end
    end

    // Sequencer FSM with registered memory-side and response outputs.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            req_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_out_q     <= 1'b0;
            rdata_q      <= '0;
            resp_valid_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|grant) begin
                        req_q        <= sel_req;
                        owner_q      <= grant[1];
                        last_grant_q <= grant[1];
                        we_out_q     <= sel_req.we;
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The memory edge is the end of this cycle; strobe is one cycle wide.
                    we_out_q <= 1'b0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    // Registered read data is valid now; writes report zero.
                    rdata_q      <= req_q.we ? '0 : Data_out;
                    resp_valid_q <= owner_onehot(owner_q);
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready[owner_q]) begin
                        resp_valid_q <= '0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Grant is only offered while idle; reset forces it low even if inputs are valid.
    assign req_ready = (state_q == IDLE && Reset_n) ? grant : '0;

    // Memory-side and response outputs come straight from registers.
    assign WriteEnable = we_out_q;
    assign X_addr      = req_q.addr[ADDR_BITS-1:HALF];
    assign Y_addr      = req_q.addr[HALF-1:0];
    assign Data_in     = req_q.wdata;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = rdata_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_datamem_ctrl.sv
// Directed testbench for datamem_ctrl with a behavioural datamem model.
module tb_datamem_ctrl;
    import datamem_ctrl_pkg::*;

    localparam logic [63:0] DATA_A = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] DATA_B = 64'h1111_2222_3333_4444;
    localparam logic [63:0] DATA_C = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [63:0] DATA_D = 64'h0F0F_0F0F_F0F0_F0F0;
    localparam logic [63:0] DATA_E = 64'h8000_0000_0000_0001;
    localparam logic [63:0] DATA_F = 64'h5555_5555_5555_5555;
    localparam logic [63:0] DATA_G = 64'h6666_6666_6666_6666;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_we;
    logic [31:0]   req_addr;
    logic [127:0]  req_wdata;
    logic [1:0]    resp_valid;
    logic [1:0]    resp_ready;
    logic [63:0]   resp_rdata;
    logic          we;
    logic [7:0]    x_addr;
    logic [7:0]    y_addr;
    logic [63:0]   data_in;
    logic [63:0]   data_out = '0;
    state_e        dbg_state;

    int checks = 0;
    int errors = 0;

    datamem_ctrl dut (
        .Clock       (clk),
        .Reset_n     (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .WriteEnable (we),
        .X_addr      (x_addr),
        .Y_addr      (y_addr),
        .Data_in     (data_in),
        .Data_out    (data_out),
        .dbg_state   (dbg_state)
    );

    // datamem model: registered read, old word returned on a write edge, no reset.
    logic [63:0] mem_model [int];
    always @(posedge clk) begin : mem_blk
        int a;
        a = int'({x_addr, y_addr});
        data_out <= mem_model.exists(a) ? mem_model[a] : 64'd0;
        if (we) mem_model[a] = data_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic w, input logic [15:0] a, input logic [63:0] d);
        req_we[id]             = w;
        req_addr[id*16 +: 16]  = a;
        req_wdata[id*64 +: 64] = d;
    endtask

    // Full transaction with bounded waits; used for setup traffic.
    task automatic drive_req(input int id, input logic w, input logic [15:0] a, input logic [63:0] d);
        int n;
        set_req(id, w, a, d);
        req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[id] && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (req_ready[id] !== 1'b1) begin
            errors++;
            $display("FAIL drive_accept req%0d: req_ready=%b required 1 within 20 cycles", id, req_ready[id]);
        end
        tick();
        req_valid[id] = 1'b0;
        n = 0;
        while (!resp_valid[id] && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (resp_valid[id] !== 1'b1) begin
            errors++;
            $display("FAIL drive_resp req%0d: resp_valid=%b required 1 within 20 cycles", id, resp_valid[id]);
        end
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = 2'b11;
        req_we     = '0;
        req_addr   = 32'h1234_5678;
        req_wdata  = '1;
        resp_ready = 2'b11;
        #22;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rst_resp_valid: got %b want 00", resp_valid); end
        checks++; if (resp_rdata !== 64'd0) begin errors++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", we); end
        checks++; if ({x_addr, y_addr} !== 16'h0000) begin errors++; $display("FAIL rst_xy: got %h/%h want 00/00", x_addr, y_addr); end
        checks++; if (data_in !== 64'd0) begin errors++; $display("FAIL rst_data_in: got %h want 0", data_in); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want IDLE", dbg_state); end
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        // write 0x0304
        set_req(0, 1'b1, 16'h0304, DATA_A);
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_accept: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        checks++; if (dbg_state !== ACCESS) begin errors++; $display("FAIL wr_state_access: got %0d want ACCESS", dbg_state); end
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL wr_we_access: got %b want 1", we); end
        checks++; if (x_addr !== 8'h03 || y_addr !== 8'h04) begin errors++; $display("FAIL wr_xy: got %h/%h want 03/04", x_addr, y_addr); end
        checks++; if (data_in !== DATA_A) begin errors++; $display("FAIL wr_data_in: got %h want %h", data_in, DATA_A); end
        tick();
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL wr_we_wait: got %b want 0", we); end
        checks++; if (x_addr !== 8'h03 || y_addr !== 8'h04) begin errors++; $display("FAIL wr_xy_hold: got %h/%h want 03/04", x_addr, y_addr); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL wr_resp_early: got %b want 00", resp_valid); end
        tick();
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL wr_resp_valid: got %b want 01", resp_valid); end
        checks++; if (resp_rdata !== 64'd0) begin errors++; $display("FAIL wr_resp_rdata: got %h want 0", resp_rdata); end
        tick();
        checks++; if (dbg_state !== IDLE || resp_valid !== 2'b00) begin errors++; $display("FAIL wr_back_idle: state %0d resp_valid %b want IDLE/00", dbg_state, resp_valid); end
        // read back 0x0304
        set_req(0, 1'b0, 16'h0304, 64'd0);
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rd_accept: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL rd_we: got %b want 0", we); end
        tick();
        tick();
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL rd_resp_valid_cycle3: got %b want 01", resp_valid); end
        checks++; if (resp_rdata !== DATA_A) begin errors++; $display("FAIL rd_rdata: got %h want %h", resp_rdata, DATA_A); end
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [4];
        logic [1:0] g;
        drive_req(0, 1'b1, 16'h0001, DATA_B);
        drive_req(1, 1'b1, 16'h0002, DATA_C);
`ifdef DATAMEM_CTRL_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        set_req(0, 1'b0, 16'h0001, 64'd0);
        set_req(1, 1'b0, 16'h0002, 64'd0);
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            g = req_ready;
            checks++; if (g !== exp_g[k]) begin errors++; $display("FAIL cont_grant[%0d]: got %b want %b", k, g, exp_g[k]); end
            tick();
            tick();
            tick();
            checks++; if (resp_valid !== exp_g[k]) begin errors++; $display("FAIL cont_resp[%0d]: got %b want %b", k, resp_valid, exp_g[k]); end
            checks++; if (resp_rdata !== (exp_g[k] == 2'b01 ? DATA_B : DATA_C)) begin
                errors++; $display("FAIL cont_rdata[%0d]: got %h want %h", k, resp_rdata, (exp_g[k] == 2'b01 ? DATA_B : DATA_C));
            end
            tick();
        end
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        resp_ready = 2'b01;
        set_req(1, 1'b0, 16'h0002, 64'd0);
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_accept: got %b want 10", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        checks++; if (resp_valid !== 2'b10 || resp_rdata !== DATA_C) begin errors++; $display("FAIL bp_resp: got %b/%h want 10/%h", resp_valid, resp_rdata, DATA_C); end
        set_req(0, 1'b0, 16'h0001, 64'd0);
        req_valid = 2'b01;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (resp_valid !== 2'b10 || resp_rdata !== DATA_C) begin errors++; $display("FAIL bp_hold[%0d]: got %b/%h want 10/%h", k, resp_valid, resp_rdata, DATA_C); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_no_ready[%0d]: got %b want 00", k, req_ready); end
        end
        resp_ready = 2'b11;
        tick();
        checks++; if (dbg_state !== IDLE || resp_valid !== 2'b00) begin errors++; $display("FAIL bp_release: state %0d resp_valid %b want IDLE/00", dbg_state, resp_valid); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_next_ready: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        checks++; if (resp_valid !== 2'b01 || resp_rdata !== DATA_B) begin errors++; $display("FAIL bp_next_resp: got %b/%h want 01/%h", resp_valid, resp_rdata, DATA_B); end
        tick();
    endtask

    task automatic test_write_resp();
        int          t_id  [3] = '{0, 1, 1};
        logic        t_we  [3] = '{1'b1, 1'b1, 1'b0};
        logic [15:0] t_adr [3] = '{16'h0000, 16'hFFFF, 16'hFFFF};
        logic [63:0] t_wd  [3] = '{DATA_D, DATA_E, 64'd0};
        logic [7:0]  t_x   [3] = '{8'h00, 8'hFF, 8'hFF};
        logic [7:0]  t_y   [3] = '{8'h00, 8'hFF, 8'hFF};
        logic [63:0] t_rd  [3] = '{64'd0, 64'd0, DATA_E};
        logic [1:0]  oh;
        for (int k = 0; k < 3; k++) begin
            oh = (t_id[k] == 1) ? 2'b10 : 2'b01;
            set_req(t_id[k], t_we[k], t_adr[k], t_wd[k]);
            req_valid = oh;
            #1;
            checks++; if (req_ready !== oh) begin errors++; $display("FAIL wresp_accept[%0d]: got %b want %b", k, req_ready, oh); end
            tick();
            req_valid = 2'b00;
            checks++; if (we !== t_we[k]) begin errors++; $display("FAIL wresp_we[%0d]: got %b want %b", k, we, t_we[k]); end
            checks++; if (x_addr !== t_x[k] || y_addr !== t_y[k]) begin errors++; $display("FAIL wresp_xy[%0d]: got %h/%h want %h/%h", k, x_addr, y_addr, t_x[k], t_y[k]); end
            tick();
            tick();
            checks++; if (resp_valid !== oh) begin errors++; $display("FAIL wresp_valid[%0d]: got %b want %b", k, resp_valid, oh); end
            checks++; if (resp_rdata !== t_rd[k]) begin errors++; $display("FAIL wresp_rdata[%0d]: got %h want %h", k, resp_rdata, t_rd[k]); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        drive_req(0, 1'b1, 16'h0010, DATA_F);
        set_req(0, 1'b1, 16'h0010, DATA_G);
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL rm_we_before: got %b want 1", we); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL rm_we_drop: got %b want 0", we); end
        checks++; if ({x_addr, y_addr} !== 16'h0000 || data_in !== 64'd0) begin errors++; $display("FAIL rm_outputs: got %h%h/%h want 0000/0", x_addr, y_addr, data_in); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rm_state: got %0d want IDLE", dbg_state); end
        set_req(0, 1'b0, 16'h0010, 64'd0);
        set_req(1, 1'b0, 16'h0002, 64'd0);
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (resp_valid !== 2'b00 || req_ready !== 2'b00) begin errors++; $display("FAIL rm_quiet[%0d]: resp_valid %b req_ready %b want 00/00", k, resp_valid, req_ready); end
        end
        #2;
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_first_grant: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL rm_read_valid: got %b want 01", resp_valid); end
        checks++; if (resp_rdata !== DATA_F) begin errors++; $display("FAIL rm_mem_intact: got %h want %h", resp_rdata, DATA_F); end
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_backpressure();
        test_write_resp();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
